// File: rtl/llc_mem_scheduler.sv
// Arbitrates the single cacheline memory port between I-cache reads, D-cache reads and a
// one-entry write-back buffer that absorbs D-cache writebacks and drains when memory is idle.
module llc_mem_scheduler #(
    parameter int unsigned LINE_W   = 256,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_address,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic              mmem_read,
    output logic              mmem_write,
    output logic [ADDR_W-1:0] mmem_address,
    output logic [LINE_W-1:0] mmem_wdata,
    input  logic [LINE_W-1:0] mmem_rdata,
    input  logic              mmem_resp,
    output logic              wb_pending
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        WB_DRAIN,
        RESP_I,
        RESP_D
    } state_t;

    state_t              r_state;
    logic                r_buf_valid;
    logic [ADDR_W-1:0]   r_buf_addr;
    logic [LINE_W-1:0]   r_buf_data;
    logic [LINE_W-1:0]   r_rdata;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_rr_last_d;
    logic                r_imem_resp;
    logic                r_dmem_resp;
    logic                r_mmem_read;
    logic                r_mmem_write;
    logic [ADDR_W-1:0]   r_mmem_address;

    logic                w_rd_req;
    logic                w_grant_i;
    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_rd_hit;
    logic                w_wr_same;
    logic                w_hold_full;
    logic                w_drain;

    assign w_rd_req    = imem_read | dmem_read;
    assign w_grant_i   = imem_read & (~dmem_read | r_rr_last_d);
    assign w_req_addr  = w_grant_i ? imem_address : dmem_address;
    assign w_rd_hit    = r_buf_valid &
                         (w_req_addr[ADDR_W-1:OFFSET_W] == r_buf_addr[ADDR_W-1:OFFSET_W]);
    assign w_wr_same   = r_buf_valid &
                         (dmem_address[ADDR_W-1:OFFSET_W] == r_buf_addr[ADDR_W-1:OFFSET_W]);
    assign w_hold_full = (r_hold_cnt == HOLD_W'(MAX_HOLD));
    // Drain on hold expiry, on a conflicting writeback, or whenever nothing else wants the port.
    assign w_drain     = r_buf_valid &
                         (w_hold_full | (~w_rd_req & ~(dmem_write & w_wr_same)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_buf_valid    <= 1'b0;
            r_buf_addr     <= '0;
            r_buf_data     <= '0;
            r_rdata        <= '0;
            r_hold_cnt     <= '0;
            r_rr_last_d    <= 1'b1;
            r_imem_resp    <= 1'b0;
            r_dmem_resp    <= 1'b0;
            r_mmem_read    <= 1'b0;
            r_mmem_write   <= 1'b0;
            r_mmem_address <= '0;
        end else begin
            if (r_buf_valid && r_state != WB_DRAIN && !w_hold_full)
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);

            case (r_state)
                IDLE: begin
                    if (w_drain) begin
                        r_mmem_write   <= 1'b1;
                        r_mmem_address <= r_buf_addr;
                        r_state        <= WB_DRAIN;
                    end else if (w_rd_req) begin
                        r_rr_last_d <= ~w_grant_i;
                        if (w_rd_hit) begin
                            r_rdata <= r_buf_data;
                            if (w_grant_i) begin
                                r_imem_resp <= 1'b1;
                                r_state     <= RESP_I;
                            end else begin
                                r_dmem_resp <= 1'b1;
                                r_state     <= RESP_D;
                            end
                        end else begin
                            r_mmem_read    <= 1'b1;
                            r_mmem_address <= w_req_addr;
                            r_state        <= w_grant_i ? I_RD : D_RD;
                        end
                    end else if (dmem_write) begin
                        r_buf_valid <= 1'b1;
                        r_buf_addr  <= dmem_address;
                        r_buf_data  <= dmem_wdata;
                        r_hold_cnt  <= '0;
                        r_dmem_resp <= 1'b1;
                        r_state     <= RESP_D;
                    end
                end
                I_RD, D_RD: begin
                    if (mmem_resp) begin
                        r_mmem_read <= 1'b0;
                        r_rdata     <= mmem_rdata;
                        if (r_state == I_RD) begin
                            r_imem_resp <= 1'b1;
                            r_state     <= RESP_I;
                        end else begin
                            r_dmem_resp <= 1'b1;
                            r_state     <= RESP_D;
                        end
                    end
                end
                WB_DRAIN: begin
                    if (mmem_resp) begin
                        r_mmem_write <= 1'b0;
                        r_buf_valid  <= 1'b0;
                        r_hold_cnt   <= '0;
                        r_state      <= IDLE;
                    end
                end
                RESP_I: begin
                    r_imem_resp <= 1'b0;
                    r_state     <= IDLE;
                end
                RESP_D: begin
                    r_dmem_resp <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_rdata   = r_rdata;
    assign dmem_rdata   = r_rdata;
    assign imem_resp    = r_imem_resp;
    assign dmem_resp    = r_dmem_resp;
    assign mmem_read    = r_mmem_read;
    assign mmem_write   = r_mmem_write;
    assign mmem_address = r_mmem_address;
    assign mmem_wdata   = r_buf_data;
    assign wb_pending   = r_buf_valid;

endmodule

// File: tb/tb_llc_mem_scheduler.sv
// Directed bench for llc_mem_scheduler: behavioural memory with programmable latency,
// requester tasks, and hand-derived expectations for arbitration, buffering and reset.
module tb_llc_mem_scheduler;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int MAX_HOLD = 16;
    localparam int TMO      = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              imem_read = 1'b0;
    logic [ADDR_W-1:0] imem_address = '0;
    logic [LINE_W-1:0] imem_rdata;
    logic              imem_resp;
    logic              dmem_read = 1'b0;
    logic              dmem_write = 1'b0;
    logic [ADDR_W-1:0] dmem_address = '0;
    logic [LINE_W-1:0] dmem_wdata = '0;
    logic [LINE_W-1:0] dmem_rdata;
    logic              dmem_resp;
    logic              mmem_read;
    logic              mmem_write;
    logic [ADDR_W-1:0] mmem_address;
    logic [LINE_W-1:0] mmem_wdata;
    logic [LINE_W-1:0] mmem_rdata = '0;
    logic              mmem_resp = 1'b0;
    logic              wb_pending;

    always #5 clk = ~clk;

    llc_mem_scheduler #(
        .LINE_W   (LINE_W),
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mmem_read    (mmem_read),
        .mmem_write   (mmem_write),
        .mmem_address (mmem_address),
        .mmem_wdata   (mmem_wdata),
        .mmem_rdata   (mmem_rdata),
        .mmem_resp    (mmem_resp),
        .wb_pending   (wb_pending)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural memory: untouched lines read back a pattern derived from the line address.
    logic [LINE_W-1:0] mem [logic [ADDR_W-OFFSET_W-1:0]];
    int                mem_lat = 4;
    int                mcnt = 0;
    int                n_mrd = 0;
    int                n_mwr = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    function automatic logic [LINE_W-1:0] rd_line(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] base;
        base = {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (mem.exists(a[ADDR_W-1:OFFSET_W])) return mem[a[ADDR_W-1:OFFSET_W]];
        return {8{base ^ 32'hC0DE_0000}};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mcnt      = 0;
                mmem_resp = 1'b0;
            end else if (mmem_resp) begin
                mmem_resp = 1'b0;
            end else if (mmem_read || mmem_write) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    mcnt      = 0;
                    mmem_resp = 1'b1;
                    if (mmem_write) begin
                        mem[mmem_address[ADDR_W-1:OFFSET_W]] = mmem_wdata;
                        last_wr_addr = mmem_address;
                        n_mwr++;
                    end else begin
                        mmem_rdata = rd_line(mmem_address);
                        n_mrd++;
                    end
                end
            end
        end
    end

    int                cyc = 0;
    int                last_mresp_cyc = 0;
    int                n_iresp = 0;
    int                iresp_at_wr = -1;
    logic [ADDR_W-1:0] last_rd_addr = '0;

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(negedge clk);
            if (mmem_resp) last_mresp_cyc = cyc;
            if (mmem_read) last_rd_addr = mmem_address;
            if (mmem_read || mmem_write)
                check("rw_excl", LINE_W'(mmem_read && mmem_write), '0);
            if (imem_resp || dmem_resp)
                check("one_resp", LINE_W'(imem_resp && dmem_resp), '0);
            if (imem_resp) n_iresp++;
            if (mmem_write && iresp_at_wr < 0) iresp_at_wr = n_iresp;
        end
    end

    task automatic clr_counts();
        n_mrd       = 0;
        n_mwr       = 0;
        n_iresp     = 0;
        iresp_at_wr = -1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        imem_read    = 1'b0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        imem_address = '0;
        dmem_address = '0;
        dmem_wdata   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mem.delete();
        clr_counts();
    endtask

    task automatic chk_outs_zero(input string tag);
        check({tag, "_imem_resp"}, LINE_W'(imem_resp), '0);
        check({tag, "_dmem_resp"}, LINE_W'(dmem_resp), '0);
        check({tag, "_mmem_read"}, LINE_W'(mmem_read), '0);
        check({tag, "_mmem_write"}, LINE_W'(mmem_write), '0);
        check({tag, "_mmem_addr"}, LINE_W'(mmem_address), '0);
        check({tag, "_mmem_wdata"}, mmem_wdata, '0);
        check({tag, "_imem_rdata"}, imem_rdata, '0);
        check({tag, "_dmem_rdata"}, dmem_rdata, '0);
        check({tag, "_wb_pending"}, LINE_W'(wb_pending), '0);
    endtask

    task automatic i_read(input logic [ADDR_W-1:0] a, output logic [LINE_W-1:0] d,
                          output int n);
        imem_address = a;
        imem_read    = 1'b1;
        n = 0;
        while (n < TMO) begin
            @(negedge clk);
            n++;
            if (imem_resp) break;
        end
        if (!imem_resp) check("i_resp_tmo", LINE_W'(imem_resp), LINE_W'(1));
        d = imem_rdata;
        imem_read = 1'b0;
    endtask

    task automatic d_op(input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] wd, output logic [LINE_W-1:0] d,
                        output int n);
        dmem_address = a;
        dmem_wdata   = wd;
        dmem_write   = wr;
        dmem_read    = ~wr;
        n = 0;
        while (n < TMO) begin
            @(negedge clk);
            n++;
            if (dmem_resp) break;
        end
        if (!dmem_resp) check("d_resp_tmo", LINE_W'(dmem_resp), LINE_W'(1));
        d = dmem_rdata;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
    endtask

    // Raises both read requests together; returns which side was served first (0=I, 1=D).
    task automatic both_round(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                              output int first, output int second);
        bit done_i = 0;
        bit done_d = 0;
        int k = 0;
        first  = -1;
        second = -1;
        imem_address = ia;
        dmem_address = da;
        imem_read    = 1'b1;
        dmem_read    = 1'b1;
        while (k < TMO && !(done_i && done_d)) begin
            @(negedge clk);
            k++;
            if (imem_resp) begin
                check("rr_i_data", imem_rdata, rd_line(ia));
                imem_read = 1'b0;
                done_i = 1;
                if (first < 0) first = 0; else second = 0;
            end
            if (dmem_resp) begin
                check("rr_d_data", dmem_rdata, rd_line(da));
                dmem_read = 1'b0;
                done_d = 1;
                if (first < 0) first = 1; else second = 1;
            end
        end
        check("rr_both_done", LINE_W'({done_i, done_d}), LINE_W'(2'b11));
        imem_read = 1'b0;
        dmem_read = 1'b0;
    endtask

    logic [LINE_W-1:0] d;
    int                n;
    int                f, s;
    logic [LINE_W-1:0] dat_a = {8{32'hAAAA_0001}};
    logic [LINE_W-1:0] dat_b = {8{32'hBBBB_0002}};
    logic [LINE_W-1:0] dat_c = {8{32'hCCCC_0003}};
    logic [LINE_W-1:0] dat_e = {8{32'hEEEE_0005}};

    initial begin
        // 1: reset state, then a plain I-cache miss
        do_reset();
        chk_outs_zero("rst");
        mem_lat = 4;
        i_read(32'h100, d, n);
        check("t1_rdata", d, rd_line(32'h100));
        check("t1_mmem_addr", LINE_W'(last_rd_addr), LINE_W'(32'h100));
        check("t1_resp_lat", LINE_W'(cyc - last_mresp_cyc), LINE_W'(1));
        check("t1_n_mrd", LINE_W'(n_mrd), LINE_W'(1));
        @(negedge clk);
        check("t1_resp_pulse", LINE_W'(imem_resp), '0);

        // 2: round-robin between simultaneous I and D reads
        do_reset();
        mem_lat = 2;
        both_round(32'h1100, 32'h2200, f, s);
        check("t2_r1_first", LINE_W'(f), LINE_W'(0));
        check("t2_r1_second", LINE_W'(s), LINE_W'(1));
        both_round(32'h1120, 32'h2220, f, s);
        check("t2_r2_first", LINE_W'(f), LINE_W'(0));
        check("t2_r2_second", LINE_W'(s), LINE_W'(1));
        i_read(32'h1140, d, n);
        check("t2_single_i", d, rd_line(32'h1140));
        both_round(32'h1160, 32'h2260, f, s);
        check("t2_r3_first", LINE_W'(f), LINE_W'(1));
        check("t2_r3_second", LINE_W'(s), LINE_W'(0));

        // 3: writeback buffered, read of same line served from buffer
        do_reset();
        mem_lat = 3;
        d_op(1'b1, 32'h200, dat_a, d, n);
        d_op(1'b0, 32'h200, '0, d, n);
        check("t3_hit_data", d, dat_a);
        check("t3_hit_lat", LINE_W'(n), LINE_W'(2));
        check("t3_no_mrd", LINE_W'(n_mrd), '0);
        check("t3_wb_pending", LINE_W'(wb_pending), LINE_W'(1));
        repeat (10) @(negedge clk);
        check("t3_drained", LINE_W'(wb_pending), '0);
        check("t3_mem_a", rd_line(32'h200), dat_a);

        // 4: conflicting writeback drains the old line first
        do_reset();
        mem_lat = 3;
        d_op(1'b1, 32'h200, dat_a, d, n);
        d_op(1'b1, 32'h220, dat_b, d, n);
        check("t4_n_mwr", LINE_W'(n_mwr), LINE_W'(1));
        check("t4_wr_addr", LINE_W'(last_wr_addr), LINE_W'(32'h200));
        check("t4_mem_a", rd_line(32'h200), dat_a);
        check("t4_wb_pending", LINE_W'(wb_pending), LINE_W'(1));
        d_op(1'b0, 32'h220, '0, d, n);
        check("t4_hit_b", d, dat_b);
        check("t4_no_mrd", LINE_W'(n_mrd), '0);
        repeat (10) @(negedge clk);
        check("t4_mem_b", rd_line(32'h220), dat_b);

        // 5: continuous I reads; hold counter forces the drain after four reads
        do_reset();
        mem_lat = 2;
        d_op(1'b1, 32'h300, dat_c, d, n);
        for (int k = 0; k < 6; k++) begin
            i_read(32'h1000 + 32'(k) * 32'h20, d, n);
            check("t5_rdata", d, rd_line(32'h1000 + 32'(k) * 32'h20));
        end
        check("t5_reads_before_drain", LINE_W'(iresp_at_wr), LINE_W'(4));
        check("t5_n_mwr", LINE_W'(n_mwr), LINE_W'(1));
        check("t5_mem_c", rd_line(32'h300), dat_c);
        check("t5_wb_pending", LINE_W'(wb_pending), '0);

        // 6: reset while a D read is outstanding, with a line buffered
        do_reset();
        mem_lat = 10;
        d_op(1'b1, 32'h400, dat_e, d, n);
        dmem_address = 32'h500;
        dmem_read    = 1'b1;
        n = 0;
        while (n < TMO && !mmem_read) begin
            @(negedge clk);
            n++;
        end
        check("t6_mmem_read_seen", LINE_W'(mmem_read), LINE_W'(1));
        check("t6_wb_before", LINE_W'(wb_pending), LINE_W'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_outs_zero("t6_rst");
        dmem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clr_counts();
        mem_lat = 2;
        i_read(32'h600, d, n);
        check("t6_after_data", d, rd_line(32'h600));
        check("t6_after_mrd", LINE_W'(n_mrd), LINE_W'(1));
        check("t6_after_wb", LINE_W'(wb_pending), '0);
        check("t6_no_mwr", LINE_W'(n_mwr), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
